traffic_light_monitor: RTL and testbench



---
 rtl/tlm_pkg.sv | 59 +++++
 rtl/tlm_lane_checker.sv | 119 +++++++++++
 rtl/traffic_light_monitor.sv | 167 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tlm_pkg
//  Description : Shared definitions for the traffic light monitor.
//                Colour encodings, fault codes, lane indices and small helper
//                functions used by the lane checkers and the top level.
//  Revision    : 1.0 - initial release
// ============================================================================
package tlm_pkg;

    // One-hot colour encodings on a 3-bit light bus {red, yellow, green}.
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Fault codes reported on fault_code.
    typedef enum logic [2:0] {
        FC_NONE     = 3'd0,
        FC_ENC      = 3'd1,
        FC_SEQ      = 3'd2,
        FC_YSHORT   = 3'd3,
        FC_YLONG    = 3'd4,
        FC_CONFLICT = 3'd5,
        FC_STUCK    = 3'd6
    } fault_code_e;

    // Lane indices as reported on fault_lane.
    localparam int         NUM_LANES = 4;
    localparam logic [1:0] LANE_M1   = 2'd0;
    localparam logic [1:0] LANE_S    = 2'd1;
    localparam logic [1:0] LANE_MT   = 2'd2;
    localparam logic [1:0] LANE_M2   = 2'd3;

    // True for the three legal one-hot colours only.
    function automatic logic is_legal_colour(input logic [2:0] c);
        return (c == RED) || (c == YEL) || (c == GRN);
    endfunction

    // Allowed colour steps: hold, G->Y, Y->R, R->G.
    function automatic logic is_legal_step(input logic [2:0] prev,
                                           input logic [2:0] cur);
        return (cur == prev)                   ||
               ((prev == GRN) && (cur == YEL)) ||
               ((prev == YEL) && (cur == RED)) ||
               ((prev == RED) && (cur == GRN));
    endfunction

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [1:0] lowest_lane(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) r = 2'(i);
        end
        return r;
    endfunction

endpackage : tlm_pkg
`default_nettype wire

// File: rtl/tlm_lane_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tlm_lane_checker
//  Description : Per-lane checker for one 3-bit traffic light bus. Holds the
//                previous legal colour, the yellow dwell counter and (when
//                TLM_STUCK_CHECK_EN is defined) a same-colour watchdog.
//                Produces per-lane fault flags and green / not-red status
//                for the conflict matrix in the top level.
//  Macro       : TLM_STUCK_CHECK_EN - builds the stuck-light watchdog.
//  Ports       : clk, rst (async, active-high), clr (sync clear),
//                armed (top-level first-sample flag), light[2:0],
//                enc_err, seq_err, yshort_err, ylong_err, stuck_err,
//                green, not_red.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlm_lane_checker
    import tlm_pkg::*;
#(
    parameter int YEL_MIN   = 2,
    parameter int YEL_MAX   = 5,
    parameter int STUCK_MAX = 64,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       armed,
    input  logic [2:0] light,
    output logic       enc_err,
    output logic       seq_err,
    output logic       yshort_err,
    output logic       ylong_err,
    output logic       stuck_err,
    output logic       green,
    output logic       not_red
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_YEL_MIN = CNT_W'(YEL_MIN);
    localparam logic [CNT_W-1:0] C_YEL_LIM = CNT_W'(YEL_MAX + 1);

    logic [2:0]       r_prev;
    logic             r_prev_vld;
    logic [CNT_W-1:0] r_ycnt;

    logic             w_valid;
    logic             w_chk;
    logic             w_same;
    logic [CNT_W-1:0] w_ycnt_inc;
    logic [CNT_W-1:0] w_ycnt_cur;

    assign w_valid = is_legal_colour(light);

    // Sequence-type checks need a previous legal colour captured since the
    // last reset/clear; the first sample only seeds the history.
    assign w_chk  = armed && r_prev_vld;
    assign w_same = w_chk && (light == r_prev);

    // Yellow dwell including the current sample: restarts at 1 on entry to
    // yellow and saturates rather than wrapping on a very long yellow.
    assign w_ycnt_inc = (r_ycnt == C_CNT_MAX) ? r_ycnt : r_ycnt + CNT_W'(1);
    assign w_ycnt_cur = (light != YEL) ? '0 :
                        (w_same        ? w_ycnt_inc : CNT_W'(1));

    assign enc_err    = !w_valid;
    assign seq_err    = w_chk && w_valid && !is_legal_step(r_prev, light);
    // r_ycnt still holds the dwell of the yellow that just ended.
    assign yshort_err = w_chk && (r_prev == YEL) && (light == RED) &&
                        (r_ycnt < C_YEL_MIN);
    assign ylong_err  = (light == YEL) && (w_ycnt_cur >= C_YEL_LIM);

    assign green   = (light == GRN);
    // An illegal code counts as not red so it can never mask a conflict.
    assign not_red = (light != RED);

    // An illegal sample leaves the history untouched, so a single glitch is
    // reported once as ENC instead of also producing a SEQ on recovery.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_ycnt     <= '0;
        end else if (clr) begin
            r_prev     <= '0;
            r_prev_vld <= 1'b0;
            r_ycnt     <= '0;
        end else if (w_valid) begin
            r_prev     <= light;
            r_prev_vld <= 1'b1;
            r_ycnt     <= w_ycnt_cur;
        end
    end

`ifdef TLM_STUCK_CHECK_EN
    localparam logic [CNT_W-1:0] C_STUCK_LIM = CNT_W'(STUCK_MAX);

    logic [CNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0] w_wcnt_cur;

    // Number of consecutive samples of the current colour, this one included.
    assign w_wcnt_cur = !w_same ? CNT_W'(1) :
                        ((r_wcnt == C_CNT_MAX) ? r_wcnt : r_wcnt + CNT_W'(1));
    assign stuck_err  = w_valid && (w_wcnt_cur >= C_STUCK_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (clr) begin
            r_wcnt <= '0;
        end else if (w_valid) begin
            r_wcnt <= w_wcnt_cur;
        end
    end
`else
    assign stuck_err = 1'b0;
`endif

endmodule : tlm_lane_checker
`default_nettype wire

// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_monitor
//  Description : Receive-side supervisor for the four-lane traffic light
//                controller (M1, S, MT, M2). Samples every light bus each
//                clock, checks encoding, colour sequence, yellow dwell,
//                cross-lane green conflicts and (optionally) stuck lights,
//                and latches the first fault with its code and lane.
//                Never drives the lights.
//  Macro       : TLM_STUCK_CHECK_EN - enables the stuck-light watchdog
//                (fault code 6); without it code 6 is never produced.
//  Ports       : clk, rst (async, active-high),
//                light_M1 / light_S / light_MT / light_M2 [2:0] {R,Y,G},
//                clr (sync clear of fault latch, counter and re-arm),
//                fault, fault_code[2:0], fault_lane[1:0], cycle_cnt[15:0].
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor
    import tlm_pkg::*;
#(
    parameter int YEL_MIN   = 2,
    parameter int YEL_MAX   = 5,
    parameter int STUCK_MAX = 64,
    parameter int CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  light_M1,
    input  logic [2:0]  light_S,
    input  logic [2:0]  light_MT,
    input  logic [2:0]  light_M2,
    input  logic        clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [1:0]  fault_lane,
    output logic [15:0] cycle_cnt
);

    logic [2:0]           w_light [NUM_LANES];
    logic [NUM_LANES-1:0] w_enc;
    logic [NUM_LANES-1:0] w_seq;
    logic [NUM_LANES-1:0] w_yshort;
    logic [NUM_LANES-1:0] w_ylong;
    logic [NUM_LANES-1:0] w_stuck;
    logic [NUM_LANES-1:0] w_green;
    logic [NUM_LANES-1:0] w_not_red;
    logic [NUM_LANES-1:0] w_conf;

    logic                 w_hit;
    fault_code_e          w_code;
    logic [1:0]           w_lane;

    logic                 r_armed;
    logic                 r_fault;
    fault_code_e          r_code;
    logic [1:0]           r_lane;
    logic [15:0]          r_cycle_cnt;

    assign w_light[LANE_M1] = light_M1;
    assign w_light[LANE_S]  = light_S;
    assign w_light[LANE_MT] = light_MT;
    assign w_light[LANE_M2] = light_M2;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            tlm_lane_checker #(
                .YEL_MIN   (YEL_MIN),
                .YEL_MAX   (YEL_MAX),
                .STUCK_MAX (STUCK_MAX),
                .CNT_W     (CNT_W)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .clr        (clr),
                .armed      (r_armed),
                .light      (w_light[gi]),
                .enc_err    (w_enc[gi]),
                .seq_err    (w_seq[gi]),
                .yshort_err (w_yshort[gi]),
                .ylong_err  (w_ylong[gi]),
                .stuck_err  (w_stuck[gi]),
                .green      (w_green[gi]),
                .not_red    (w_not_red[gi])
            );
        end
    endgenerate

    // Conflict matrix. w_conf marks every green lane taking part in a
    // conflict so the report lands on the lowest-numbered one.
    //  - S green needs all other lanes red; any other green lane is involved.
    //  - MT green needs M2 red; M2 is involved only if it is itself green.
    //  - M1 with M2 and M1 with MT are compatible pairs.
    always_comb begin
        w_conf = '0;
        if (w_green[LANE_S] &&
            (w_not_red[LANE_M1] || w_not_red[LANE_MT] || w_not_red[LANE_M2])) begin
            w_conf = w_conf | w_green;
        end
        if (w_green[LANE_MT] && w_not_red[LANE_M2]) begin
            w_conf[LANE_MT] = 1'b1;
            w_conf[LANE_M2] = w_conf[LANE_M2] | w_green[LANE_M2];
        end
    end

    // Priority: CONFLICT > ENC > SEQ > YSHORT > YLONG > STUCK, then lowest lane.
    always_comb begin
        w_hit  = 1'b1;
        w_code = FC_NONE;
        w_lane = LANE_M1;
        if (|w_conf) begin
            w_code = FC_CONFLICT;
            w_lane = lowest_lane(w_conf);
        end else if (|w_enc) begin
            w_code = FC_ENC;
            w_lane = lowest_lane(w_enc);
        end else if (|w_seq) begin
            w_code = FC_SEQ;
            w_lane = lowest_lane(w_seq);
        end else if (|w_yshort) begin
            w_code = FC_YSHORT;
            w_lane = lowest_lane(w_yshort);
        end else if (|w_ylong) begin
            w_code = FC_YLONG;
            w_lane = lowest_lane(w_ylong);
        end else if (|w_stuck) begin
            w_code = FC_STUCK;
            w_lane = lowest_lane(w_stuck);
        end else begin
            w_hit  = 1'b0;
        end
    end

    // Sticky first-fault latch. clr takes precedence over a fault detected
    // in the same cycle; the sample after clr is treated as a first sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_fault     <= 1'b0;
            r_code      <= FC_NONE;
            r_lane      <= LANE_M1;
            r_cycle_cnt <= '0;
        end else if (clr) begin
            r_armed     <= 1'b0;
            r_fault     <= 1'b0;
            r_code      <= FC_NONE;
            r_lane      <= LANE_M1;
            r_cycle_cnt <= '0;
        end else begin
            r_armed <= 1'b1;
            if (r_cycle_cnt != 16'hFFFF) begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
            if (!r_fault && w_hit) begin
                r_fault <= 1'b1;
                r_code  <= w_code;
                r_lane  <= w_lane;
            end
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign fault_lane = r_lane;
    assign cycle_cnt  = r_cycle_cnt;

endmodule : traffic_light_monitor
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_traffic_light_monitor
//  Description : Self-checking bench for traffic_light_monitor. A reference
//                model kept in colour/run-length terms predicts the outputs
//                after every sampling edge; expectations go into a queue that
//                an independent monitor drains and compares.
//  Macro       : TLM_STUCK_CHECK_EN - model includes the stuck watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    localparam int YEL_MIN   = 2;
    localparam int YEL_MAX   = 5;
    localparam int STUCK_MAX = 64;
    localparam int CNT_W     = 8;

    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic [2:0]  light_M1 = R;
    logic [2:0]  light_S  = R;
    logic [2:0]  light_MT = R;
    logic [2:0]  light_M2 = R;
    logic        fault;
    logic [2:0]  fault_code;
    logic [1:0]  fault_lane;
    logic [15:0] cycle_cnt;

    initial forever #5 clk = ~clk;

    traffic_light_monitor #(
        .YEL_MIN   (YEL_MIN),
        .YEL_MAX   (YEL_MAX),
        .STUCK_MAX (STUCK_MAX),
        .CNT_W     (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .light_M1   (light_M1),
        .light_S    (light_S),
        .light_MT   (light_MT),
        .light_M2   (light_M2),
        .clr        (clr),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_lane (fault_lane),
        .cycle_cnt  (cycle_cnt)
    );

    typedef struct {
        bit fault;
        int code;
        int lane;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- reference model ----------------
    // Colours as 0=red, 1=yellow, 2=green, -1 = illegal / no history.
    int m_prev[4];
    int m_run[4];
    bit m_fault;
    int m_code, m_lane, m_cnt;

    function automatic int decode(input logic [2:0] v);
        case (v)
            3'b100:  return 0;
            3'b010:  return 1;
            3'b001:  return 2;
            default: return -1;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = -1;
            m_run[i]  = 0;
        end
        m_fault = 0; m_code = 0; m_lane = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input logic [2:0] a, input logic [2:0] b,
                                       input logic [2:0] c, input logic [2:0] d,
                                       input bit cl);
        logic [2:0] l[4];
        int  col[4];
        int  run[4];
        bit  flg[7][4];
        int  prio[6] = '{5, 1, 2, 3, 4, 6};
        bit  grn[4];
        bit  nred[4];
        bit  found;
        bit  hp;
        int  code, lane;
        if (cl) begin
            model_reset();
            return;
        end
        l[0] = a; l[1] = b; l[2] = c; l[3] = d;
        flg = '{default: 1'b0};
        for (int i = 0; i < 4; i++) begin
            col[i]  = decode(l[i]);
            hp      = (m_prev[i] >= 0);
            run[i]  = (hp && col[i] == m_prev[i]) ? m_run[i] + 1 : 1;
            grn[i]  = (col[i] == 2);
            nred[i] = (l[i] != R);
            flg[1][i] = (col[i] < 0);
            // legal next colour in the R->G->Y->R cycle is (prev+2) mod 3
            flg[2][i] = hp && col[i] >= 0 && col[i] != m_prev[i] &&
                        col[i] != (m_prev[i] + 2) % 3;
            flg[3][i] = hp && m_prev[i] == 1 && col[i] == 0 && m_run[i] < YEL_MIN;
            flg[4][i] = (col[i] == 1) && (run[i] >= YEL_MAX + 1);
`ifdef TLM_STUCK_CHECK_EN
            flg[6][i] = (col[i] >= 0) && (run[i] >= STUCK_MAX);
`endif
        end
        if (grn[1] && (nred[0] || nred[2] || nred[3]))
            for (int i = 0; i < 4; i++) if (grn[i]) flg[5][i] = 1'b1;
        if (grn[2] && nred[3]) begin
            flg[5][2] = 1'b1;
            if (grn[3]) flg[5][3] = 1'b1;
        end
        found = 0; code = 0; lane = 0;
        for (int p = 0; p < 6; p++)
            for (int i = 0; i < 4; i++)
                if (!found && flg[prio[p]][i]) begin
                    found = 1; code = prio[p]; lane = i;
                end
        if (!m_fault && found) begin
            m_fault = 1; m_code = code; m_lane = lane;
        end
        for (int i = 0; i < 4; i++) begin
            if (col[i] >= 0) begin
                m_prev[i] = col[i];
                m_run[i]  = run[i];
            end
        end
        if (m_cnt < 65535) m_cnt++;
    endfunction

    // ---------------- legal controller phases ----------------
    int cur_ph, ph_left;

    task automatic phase_lights(input int p, output logic [2:0] a, output logic [2:0] b,
                                output logic [2:0] c, output logic [2:0] d);
        case (p)
            0:       begin a = G; b = R; c = R; d = G; end
            1:       begin a = G; b = R; c = R; d = Y; end
            2:       begin a = G; b = R; c = G; d = R; end
            3:       begin a = Y; b = R; c = Y; d = R; end
            4:       begin a = R; b = G; c = R; d = R; end
            default: begin a = R; b = Y; c = R; d = R; end
        endcase
    endtask

    function automatic int phase_len(input int p, input bit rnd);
        int dflt[6] = '{7, 2, 5, 2, 3, 2};
        if (!rnd) return dflt[p];
        if (p % 2 == 1)
            return ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 7))
                                               : int'($urandom_range(YEL_MIN, YEL_MAX));
        return int'($urandom_range(1, 9));
    endfunction

    function automatic void restart_phases(input bit rnd);
        cur_ph  = 0;
        ph_left = phase_len(0, rnd);
    endfunction

    // Inputs are applied right after a falling edge and sampled on the next rising edge.
    task automatic drive(input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input logic [2:0] d, input bit cl);
        exp_t e;
        light_M1 = a; light_S = b; light_MT = c; light_M2 = d; clr = cl;
        model_step(a, b, c, d, cl);
        e.fault = m_fault; e.code = m_code; e.lane = m_lane; e.cnt = m_cnt;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic run_phases(input int n, input bit rnd);
        logic [2:0] a, b, c, d;
        bit cl;
        for (int k = 0; k < n; k++) begin
            phase_lights(cur_ph, a, b, c, d);
            cl = 1'b0;
            if (rnd) begin
                if ($urandom_range(0, 49) == 0) begin
                    case ($urandom_range(0, 3))
                        0:       a = 3'($urandom_range(0, 7));
                        1:       b = 3'($urandom_range(0, 7));
                        2:       c = 3'($urandom_range(0, 7));
                        default: d = 3'($urandom_range(0, 7));
                    endcase
                end
                cl = m_fault ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 59) == 0);
            end
            drive(a, b, c, d, cl);
            ph_left--;
            if (ph_left == 0) begin
                cur_ph  = (cur_ph + 1) % 6;
                ph_left = phase_len(cur_ph, rnd);
            end
        end
    endtask

    task automatic check(input string name, input int got, input int expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Asserted between clock edges: outputs must clear without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_fault", int'(fault), 0);
        check("async_rst_code",  int'(fault_code), 0);
        check("async_rst_lane",  int'(fault_lane), 0);
        check("async_rst_cnt",   int'(cycle_cnt), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        restart_phases(1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_checks++;
                if (fault !== e.fault || fault_code !== 3'(e.code) ||
                    fault_lane !== 2'(e.lane) || cycle_cnt !== 16'(e.cnt)) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got fault=%0d code=%0d lane=%0d cnt=%0d, expected fault=%0d code=%0d lane=%0d cnt=%0d",
                             $time, fault, fault_code, fault_lane, cycle_cnt,
                             e.fault, e.code, e.lane, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_fault", int'(fault), 0);
        check("reset_code",  int'(fault_code), 0);
        check("reset_lane",  int'(fault_lane), 0);
        check("reset_cnt",   int'(cycle_cnt), 0);
        rst = 1'b0;

        // Legal controller cycle for 200 samples.
        restart_phases(1'b0);
        run_phases(200, 1'b0);
        check("legal_fault", int'(fault), 0);
        check("legal_cnt",   int'(cycle_cnt), 200);

        // S green while M1 green on sample 10; a later ENC on M2 is ignored.
        drive(G, R, R, G, 1'b1);
        restart_phases(1'b0);
        run_phases(9, 1'b0);
        drive(G, G, R, Y, 1'b0);
        check("conf_code", int'(fault_code), 5);
        check("conf_lane", int'(fault_lane), 0);
        drive(G, R, R, 3'b110, 1'b0);
        drive(G, R, R, R, 1'b0);
        check("conf_hold_code", int'(fault_code), 5);
        check("conf_hold_lane", int'(fault_lane), 0);

        // Reset asserted mid-run while a fault is latched.
        async_reset();

        // M1 green straight to red, then clear and resume.
        run_phases(3, 1'b0);
        drive(R, R, R, G, 1'b0);
        check("seq_code", int'(fault_code), 2);
        check("seq_lane", int'(fault_lane), 0);
        drive(R, R, R, G, 1'b1);
        check("clr_fault", int'(fault), 0);
        drive(R, R, R, G, 1'b0);
        drive(G, R, R, G, 1'b0);
        check("after_clr_fault", int'(fault), 0);

        // MT yellow for one sample then red.
        drive(G, R, G, R, 1'b1);
        drive(G, R, G, R, 1'b0);
        drive(G, R, G, R, 1'b0);
        drive(G, R, Y, R, 1'b0);
        drive(G, R, R, R, 1'b0);
        check("yshort_code", int'(fault_code), 3);
        check("yshort_lane", int'(fault_lane), 2);

        // MT yellow held six samples.
        drive(G, R, G, R, 1'b1);
        drive(G, R, G, R, 1'b0);
        drive(G, R, G, R, 1'b0);
        for (int k = 0; k < 5; k++) drive(G, R, Y, R, 1'b0);
        check("ylong_pre_fault", int'(fault), 0);
        drive(G, R, Y, R, 1'b0);
        check("ylong_code", int'(fault_code), 4);
        check("ylong_lane", int'(fault_lane), 2);

        // Illegal S code together with MT green against M2 green.
        drive(G, R, R, G, 1'b1);
        drive(G, R, R, G, 1'b0);
        drive(G, 3'b011, G, G, 1'b0);
        check("prio_code", int'(fault_code), 5);
        check("prio_lane", int'(fault_lane), 2);
        async_reset();

        // Randomised phase lengths, glitches and clears.
        restart_phases(1'b1);
        run_phases(2500, 1'b1);

        // All lanes held constant.
        async_reset();
        for (int k = 0; k < 70; k++) drive(G, R, R, G, 1'b0);
`ifdef TLM_STUCK_CHECK_EN
        check("stuck_code", int'(fault_code), 6);
        check("stuck_lane", int'(fault_lane), 0);
`else
        check("nostuck_fault", int'(fault), 0);
`endif

        // Let the monitor drain the queue, with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_traffic_light_monitor
`default_nettype wire
